// File: rtl/core_mem_requester.sv
// Per-core initiator toward the shared data-memory arbiter: issues one request pulse,
// holds both lanes through arbitration, counts the fixed read latency, returns read data.
// Optional MEM_STALL_CNT_EN adds a saturating stall_cycles counter output.
module core_mem_requester #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int DATA_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [ADDR_W-1:0] u_addr_i,
  input  logic [DATA_W-1:0] u_din_i,
  input  logic              u_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_din_i,
  input  logic              l_we_i,
  output logic              mem_req_now,
  input  logic              mem_wait,
  output logic [ADDR_W-1:0] u_addr_o,
  output logic [ADDR_W-1:0] l_addr_o,
  output logic [DATA_W-1:0] u_din_o,
  output logic [DATA_W-1:0] l_din_o,
  output logic              u_we_o,
  output logic              l_we_o,
  input  logic [DATA_W-1:0] u_data_out,
  input  logic [DATA_W-1:0] l_data_out,
  output logic              resp_valid,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic [DATA_W-1:0] u_rdata,
  output logic [DATA_W-1:0] l_rdata
);

  // state | meaning
  // IDLE  | ready for a new operation, op_ready=1
  // REQ   | one-cycle request pulse to the arbiter
  // WAIT  | arbiter stalling us; request fields held
  // PEND  | granted; counting down the read latency
  // RESP  | one-cycle response strobe with captured read data
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PEND = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DATA_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] u_addr_q, l_addr_q;
  logic [DATA_W-1:0] u_din_q, l_din_q;
  logic              u_we_q, l_we_q;
  logic [DATA_W-1:0] u_rdata_q, l_rdata_q;
  logic              accept, grant, capture;

  assign accept  = (state_q == S_IDLE) && op_valid;
  assign grant   = ((state_q == S_REQ) || (state_q == S_WAIT)) && !mem_wait;
  assign capture = (state_q == S_PEND) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid) state_d = S_REQ;
      S_REQ:   state_d = mem_wait ? S_WAIT : S_PEND;
      S_WAIT:  if (!mem_wait) state_d = S_PEND;
      S_PEND:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready    = (state_q == S_IDLE);
    mem_req_now = (state_q == S_REQ);
    resp_valid  = (state_q == S_RESP);
  end

  // Write enables drop once granted so the arbiter never sees a write twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      u_addr_q  <= '0;
      l_addr_q  <= '0;
      u_din_q   <= '0;
      l_din_q   <= '0;
      u_we_q    <= 1'b0;
      l_we_q    <= 1'b0;
      u_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (accept) begin
        u_addr_q <= u_addr_i;
        l_addr_q <= l_addr_i;
        u_din_q  <= u_din_i;
        l_din_q  <= l_din_i;
        u_we_q   <= u_we_i;
        l_we_q   <= l_we_i;
      end
      if (grant) begin
        cnt_q  <= CNT_INIT;
        u_we_q <= 1'b0;
        l_we_q <= 1'b0;
      end else if ((state_q == S_PEND) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        u_rdata_q <= u_data_out;
        l_rdata_q <= l_data_out;
      end
    end
  end

  assign u_addr_o = u_addr_q;
  assign l_addr_o = l_addr_q;
  assign u_din_o  = u_din_q;
  assign l_din_o  = l_din_q;
  assign u_we_o   = u_we_q;
  assign l_we_o   = l_we_q;
  assign u_rdata  = u_rdata_q;
  assign l_rdata  = l_rdata_q;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (((state_q == S_REQ) || (state_q == S_WAIT)) && mem_wait
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
